seven_segment: RTL and testbench



---
 rtl/seven_segment.sv | 47 ++++
 tb/tb_seven_segment.sv | 107 ++++++++++
 2 files changed

// File: rtl/seven_segment.sv
// seven_segment: BCD to seven-segment decoder with lamp test, blanking and one registered output stage.
module seven_segment #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic W,
  input  logic X,
  input  logic Y,
  input  logic Z,
  input  logic LT,
  input  logic BL,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  logic [6:0] w_sel;
  logic [6:0] r_seg;
  assign w_digit = {W, X, Y, Z};
  // Logical patterns {a,b,c,d,e,f,g}, 1 = lit; codes 10..15 blank.
  always_comb begin
    case (w_digit)
      4'd0:    w_dec = 7'b1111110;
      4'd1:    w_dec = 7'b0110000;
      4'd2:    w_dec = 7'b1101101;
      4'd3:    w_dec = 7'b1111001;
      4'd4:    w_dec = 7'b0110011;
      4'd5:    w_dec = 7'b1011011;
      4'd6:    w_dec = 7'b1011111;
      4'd7:    w_dec = 7'b1110000;
      4'd8:    w_dec = 7'b1111111;
      4'd9:    w_dec = 7'b1111011;
      default: w_dec = 7'b0000000;
    endcase
  end
  assign w_sel = (LT ? 7'b1111111 : BL ? 7'b0000000 : w_dec) ^ {7{ACTIVE_LOW}};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_seg <= {7{ACTIVE_LOW}};
    else     r_seg <= w_sel;
  assign {A, B, C, D, E, F, G} = r_seg;
endmodule

// File: tb/tb_seven_segment.sv
// tb_seven_segment: checks both polarities against a table-driven reference with directed and random digits.
module tb_seven_segment;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic W = 1'b0, X = 1'b0, Y = 1'b0, Z = 1'b0, LT = 1'b0, BL = 1'b0;
  logic a0, b0, c0, d0, e0, f0, g0;
  logic a1, b1, c1, d1, e1, f1, g1;
  logic [6:0] seg0, seg1;
  logic [6:0] tbl [0:9];
  int n_checks = 0;
  int n_fail = 0;
  assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
  assign seg1 = {a1, b1, c1, d1, e1, f1, g1};
  always #5 clk = ~clk;
  seven_segment #(.ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .W(W), .X(X), .Y(Y), .Z(Z), .LT(LT), .BL(BL),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0)
  );
  seven_segment #(.ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .W(W), .X(X), .Y(Y), .Z(Z), .LT(LT), .BL(BL),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1)
  );
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] model(input int dig, input bit lt, input bit bl, input bit al);
    logic [6:0] lit;
    lit = lt ? 7'h7f : bl ? 7'h00 : (dig < 10) ? tbl[dig] : 7'h00;
    return al ? ~lit : lit;
  endfunction
  task automatic drive(input int dig, input bit lt, input bit bl);
    {W, X, Y, Z} = 4'(dig);
    LT = lt;
    BL = bl;
  endtask
  task automatic apply(input string tag, input int dig, input bit lt, input bit bl);
    @(negedge clk);
    drive(dig, lt, bl);
    @(posedge clk);
    #1;
    check({tag, "_al0"}, seg0, model(dig, lt, bl, 1'b0));
    check({tag, "_al1"}, seg1, model(dig, lt, bl, 1'b1));
  endtask
  initial begin
    int dig;
    bit lt, bl;
    tbl[0] = 7'b1111110; tbl[1] = 7'b0110000; tbl[2] = 7'b1101101; tbl[3] = 7'b1111001;
    tbl[4] = 7'b0110011; tbl[5] = 7'b1011011; tbl[6] = 7'b1011111; tbl[7] = 7'b1110000;
    tbl[8] = 7'b1111111; tbl[9] = 7'b1111011;
    apply("pre", 2, 0, 0);
    @(negedge clk);
    drive(8, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_async_al0", seg0, 7'b0000000);
    check("rst_async_al1", seg1, 7'b1111111);
    @(posedge clk);
    #1;
    check("rst_hold_al0", seg0, 7'b0000000);
    check("rst_hold_al1", seg1, 7'b1111111);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rel_al0", seg0, 7'b1111111);
    check("rst_rel_al1", seg1, 7'b0000000);
    for (int i = 0; i < 16; i++) apply($sformatf("sweep%0d", i), i, 0, 0);
    apply("lt_1", 1, 1, 0);
    apply("bl_8", 8, 0, 1);
    apply("lt_bl", 5, 1, 1);
    apply("bl_inv", 12, 0, 1);
    apply("lt_inv", 14, 1, 0);
    apply("pol0", 0, 0, 0);
    check("pol0_lit", seg1, 7'b0000001);
    apply("pol1", 1, 0, 0);
    check("pol1_lit", seg1, 7'b1001111);
    apply("hold3", 3, 0, 0);
    @(negedge clk);
    drive(4, 0, 0);
    #1;
    check("hold_mid", seg0, 7'b1111001);
    @(posedge clk);
    #1;
    check("hold_next", seg0, 7'b0110011);
    for (int i = 0; i < 300; i++) begin
      dig = int'($urandom_range(15));
      lt = ($urandom_range(7) == 0);
      bl = ($urandom_range(5) == 0);
      apply($sformatf("rnd%0d", i), dig, lt, bl);
    end
    @(negedge clk);
    drive(8, 1, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_al0", seg0, 7'b0000000);
    check("rst_mid_al1", seg1, 7'b1111111);
    @(negedge clk);
    rst = 1'b0;
    apply("after_rst", 6, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
